sd_sector_mem_writer: RTL and testbench

Upstream packing stage for the SD-card demo's on-chip memory. Accepts the byte stream produced by the SD card read path, assembles bytes into little-endian 32-bit words, and writes them into the 64 K-word on-chip RAM through an Avalon-MM master port with per-byte enables. Software (Nios) issues one transfer per sector or partial sector and polls `busy`/`done`.

---
 rtl/sd_sector_mem_writer_if.sv | 25 ++
 rtl/sd_sector_mem_writer.sv | 119 +++++++++++
 tb/tb_sd_sector_mem_writer.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_sector_mem_writer_if.sv
// Byte-stream input plus Avalon-MM word-write master, bundled for the sector writer.
// master = the writer's view; slave = the stream source / memory fabric side.
interface sd_sector_mem_writer_if #(
    parameter int ADDR_W = 16
);
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_write;
    logic [3:0]        m_byteenable;
    logic [31:0]       m_writedata;
    logic              m_waitrequest;

    modport master (
        input  s_data, s_valid, m_waitrequest,
        output s_ready, m_address, m_chipselect, m_write, m_byteenable, m_writedata
    );

    modport slave (
        output s_data, s_valid, m_waitrequest,
        input  s_ready, m_address, m_chipselect, m_write, m_byteenable, m_writedata
    );
endinterface

// File: rtl/sd_sector_mem_writer.sv
// Packs a byte stream into little-endian 32-bit words and writes them over Avalon-MM; 5 cycles/word unstalled.
// Stream stalls (s_ready low) while a write is outstanding; m_waitrequest holds the request stable.
module sd_sector_mem_writer #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  byte_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    sd_sector_mem_writer_if.master bus
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       data_q, data_d;
    logic [3:0]        be_q, be_d;
    logic              abort_q, abort_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            lane_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            lane_q  <= lane_d;
            data_q  <= data_d;
            be_q    <= be_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        lane_d  = lane_q;
        data_d  = data_q;
        be_d    = be_q;
        abort_d = abort_q;
        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = byte_count;
                    lane_d  = '0;
                    data_d  = '0;
                    be_d    = '0;
                    state_d = (byte_count == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (abort) begin
                    // Partially packed word is discarded rather than written.
                    lane_d  = '0;
                    data_d  = '0;
                    be_d    = '0;
                    state_d = DONE;
                end else if (bus.s_valid) begin
                    for (int i = 0; i < 4; i++) begin
                        if (lane_q == 2'(i)) begin
                            data_d[8*i +: 8] = bus.s_data;
                            be_d[i]          = 1'b1;
                        end
                    end
                    lane_d = lane_q + 2'd1;
                    rem_d  = rem_q - CNT_W'(1);
                    if (lane_q == 2'd3 || rem_q == CNT_W'(1)) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (abort) begin
                    abort_d = 1'b1;
                end
                if (!bus.m_waitrequest) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    lane_d  = '0;
                    data_d  = '0;
                    be_d    = '0;
                    state_d = (rem_q == '0 || abort_q || abort) ? DONE : FILL;
                end
            end
            DONE: begin
                abort_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is a register or a direct state decode.
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign bus.s_ready      = (state_q == FILL);
    assign bus.m_write      = (state_q == WRITE);
    assign bus.m_chipselect = (state_q == WRITE);
    assign bus.m_address    = addr_q;
    assign bus.m_writedata  = data_q;
    assign bus.m_byteenable = be_q;

endmodule

// File: tb/tb_sd_sector_mem_writer.sv
// Directed bench for sd_sector_mem_writer: stream source, write logger and per-scenario tasks.
module tb_sd_sector_mem_writer;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 12;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  byte_count;
    logic              busy;
    logic              done;

    sd_sector_mem_writer_if #(.ADDR_W(ADDR_W)) bus ();

    sd_sector_mem_writer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .byte_count(byte_count), .abort(abort), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    byte unsigned      src_q[$];
    byte unsigned      xfer[$];
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_dat_q[$];
    logic [3:0]        wr_be_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_dat_q[$];
    logic [3:0]        exp_be_q[$];

    int  stall_mode = 0;   // 0 never stall, 1 random 50%, 2 hold waitrequest high
    bit  gap_en = 1'b0;
    bit  acc_flag = 1'b0;
    int  accepted = 0, done_cnt = 0, busy_cyc = 0, stall_cyc = 0, stall_viol = 0;
    bit  stalled_prev = 1'b0;
    logic [ADDR_W-1:0] held_addr;
    logic [31:0]       held_dat;
    logic [3:0]        held_be;

    // Observer on the falling edge: logs completed writes and watches stalled requests.
    always @(negedge clk) begin
        acc_flag = bus.s_valid && bus.s_ready;
        if (acc_flag) accepted++;
        if (done) done_cnt++;
        if (busy && !done) busy_cyc++;
        if (bus.m_write && !bus.m_waitrequest) begin
            wr_addr_q.push_back(bus.m_address);
            wr_dat_q.push_back(bus.m_writedata);
            wr_be_q.push_back(bus.m_byteenable);
        end
        if (stalled_prev && bus.m_write &&
            (bus.m_address !== held_addr || bus.m_writedata !== held_dat || bus.m_byteenable !== held_be))
            stall_viol++;
        stalled_prev = bus.m_write && bus.m_waitrequest && reset_n;
        if (stalled_prev) begin
            stall_cyc++;
            held_addr = bus.m_address;
            held_dat  = bus.m_writedata;
            held_be   = bus.m_byteenable;
        end
    end

    task automatic drive_loop();
        forever begin
            @(posedge clk);
            #1;
            if (acc_flag && src_q.size() > 0) src_q.delete(0);
            if (src_q.size() > 0 && !(gap_en && $urandom_range(0, 2) == 0)) begin
                bus.s_valid = 1'b1;
                bus.s_data  = src_q[0];
            end else begin
                bus.s_valid = 1'b0;
                bus.s_data  = 8'h00;
            end
            case (stall_mode)
                1:       bus.m_waitrequest = 1'($urandom_range(0, 1));
                2:       bus.m_waitrequest = 1'b1;
                default: bus.m_waitrequest = 1'b0;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); wr_dat_q.delete(); wr_be_q.delete();
        accepted = 0; done_cnt = 0; busy_cyc = 0; stall_cyc = 0; stall_viol = 0;
    endtask

    // Queue xfer[] into the source and build the expected word list from it.
    task automatic load_xfer(input logic [ADDR_W-1:0] base);
        logic [31:0] d;
        logic [3:0]  be;
        exp_addr_q.delete(); exp_dat_q.delete(); exp_be_q.delete();
        foreach (xfer[i]) src_q.push_back(xfer[i]);
        for (int w = 0; w * 4 < xfer.size(); w++) begin
            d  = '0;
            be = '0;
            for (int l = 0; l < 4; l++) begin
                if (w * 4 + l < xfer.size()) begin
                    d[8*l +: 8] = xfer[w*4+l];
                    be[l]       = 1'b1;
                end
            end
            exp_addr_q.push_back(base + ADDR_W'(w));
            exp_dat_q.push_back(d);
            exp_be_q.push_back(be);
        end
    endtask

    function automatic int writes_bad();
        int bad = 0;
        if (wr_addr_q.size() != exp_addr_q.size()) bad++;
        for (int i = 0; i < wr_addr_q.size() && i < exp_addr_q.size(); i++)
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_dat_q[i] !== exp_dat_q[i] || wr_be_q[i] !== exp_be_q[i])
                bad++;
        return bad;
    endfunction

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
        tick();
        base_addr  = b;
        byte_count = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int c0;
        c0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != c0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_mwrite(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (bus.m_write) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; byte_count = '0;
        bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.m_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, bus.s_ready, bus.m_write, bus.m_chipselect} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, bus.s_ready, bus.m_write, bus.m_chipselect});
        end
        checks++;
        if ({bus.m_address, bus.m_byteenable, bus.m_writedata} !== 52'h0) begin
            errors++; $display("FAIL reset_bus: got addr %h be %h data %h want zeros", bus.m_address, bus.m_byteenable, bus.m_writedata);
        end
        reset_n = 1'b1;
        repeat (2) tick();
        checks++;
        if ({busy, bus.s_ready, bus.m_write} !== 3'b0) begin
            errors++; $display("FAIL idle_after_reset: got %b want 000", {busy, bus.s_ready, bus.m_write});
        end
    endtask

    task automatic test_full_sector();
        bit ok;
        clear_logs();
        xfer.delete();
        for (int i = 0; i < 512; i++) xfer.push_back(8'(i));
        load_xfer(16'h0100);
        do_start(16'h0100, 12'd512);
        @(negedge clk);
        #1;
        checks++;
        if ({busy, bus.s_ready} !== 2'b11) begin
            errors++; $display("FAIL sector_start_lat: busy/s_ready got %b want 11", {busy, bus.s_ready});
        end
        wait_done(1000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sector_done: got no done want done"); end
        checks++;
        if (wr_addr_q.size() != 128 || writes_bad() != 0) begin
            errors++; $display("FAIL sector_writes: got %0d writes, %0d bad, want 128 writes, 0 bad", wr_addr_q.size(), writes_bad());
        end
        checks++;
        if (wr_dat_q.size() == 0 || wr_dat_q[0] !== 32'h03020100) begin
            errors++; $display("FAIL sector_first_word: got %h want 03020100", (wr_dat_q.size() > 0) ? wr_dat_q[0] : 32'hx);
        end
        // Cycles spent in FILL/WRITE between start and the done pulse.
        checks++;
        if (busy_cyc != 640) begin errors++; $display("FAIL sector_cycles: got %0d want 640", busy_cyc); end
        @(negedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b00 || done_cnt != 1) begin
            errors++; $display("FAIL sector_end: busy/done got %b count %0d want 00 count 1", {busy, done}, done_cnt);
        end
    endtask

    task automatic test_partial_tail();
        bit ok;
        clear_logs();
        xfer = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        load_xfer(16'h0040);
        do_start(16'h0040, 12'd7);
        wait_done(100, ok);
        checks++;
        if (!ok || wr_addr_q.size() != 2) begin
            errors++; $display("FAIL tail_count: got %0d writes done=%0d want 2 writes done=1", wr_addr_q.size(), ok);
        end else begin
            checks++;
            if (wr_addr_q[0] !== 16'h0040 || wr_dat_q[0] !== 32'hA4A3A2A1 || wr_be_q[0] !== 4'hF) begin
                errors++; $display("FAIL tail_word0: got %h/%h/%h want 0040/a4a3a2a1/f", wr_addr_q[0], wr_dat_q[0], wr_be_q[0]);
            end
            checks++;
            if (wr_addr_q[1] !== 16'h0041 || wr_dat_q[1] !== 32'h00A7A6A5 || wr_be_q[1] !== 4'h7) begin
                errors++; $display("FAIL tail_word1: got %h/%h/%h want 0041/00a7a6a5/7", wr_addr_q[1], wr_dat_q[1], wr_be_q[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_logs();
        xfer.delete();
        for (int i = 0; i < 62; i++) xfer.push_back(8'((i * 7 + 3) & 8'hFF));
        load_xfer(16'h0200);
        stall_mode = 1;
        gap_en     = 1'b1;
        do_start(16'h0200, 12'd62);
        wait_done(3000, ok);
        stall_mode = 0;
        gap_en     = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_done: got no done want done"); end
        checks++;
        if (writes_bad() != 0) begin
            errors++; $display("FAIL bp_writes: got %0d writes %0d bad want 16 writes 0 bad", wr_addr_q.size(), writes_bad());
        end
        checks++;
        if (stall_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stall_viol); end
        checks++;
        if (stall_cyc == 0) begin errors++; $display("FAIL bp_stalled: got %0d stalled cycles want >0", stall_cyc); end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_logs();
        xfer = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        load_xfer(16'hFFFF);
        do_start(16'hFFFF, 12'd8);
        wait_done(100, ok);
        checks++;
        if (!ok || wr_addr_q.size() != 2) begin
            errors++; $display("FAIL wrap_count: got %0d writes want 2", wr_addr_q.size());
        end else begin
            checks++;
            if (wr_addr_q[0] !== 16'hFFFF || wr_addr_q[1] !== 16'h0000) begin
                errors++; $display("FAIL wrap_addr: got %h,%h want ffff,0000", wr_addr_q[0], wr_addr_q[1]);
            end
            checks++;
            if (wr_dat_q[0] !== 32'h04030201 || wr_dat_q[1] !== 32'h08070605) begin
                errors++; $display("FAIL wrap_data: got %h,%h want 04030201,08070605", wr_dat_q[0], wr_dat_q[1]);
            end
        end
    endtask

    task automatic test_zero_count();
        clear_logs();
        do_start(16'h1234, 12'd0);
        @(negedge clk);
        #1;
        checks++;
        if ({done, busy, bus.m_write} !== 3'b110) begin
            errors++; $display("FAIL zero_done: done/busy/m_write got %b want 110", {done, busy, bus.m_write});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({done, busy} !== 2'b00 || wr_addr_q.size() != 0) begin
            errors++; $display("FAIL zero_end: done/busy got %b writes %0d want 00 writes 0", {done, busy}, wr_addr_q.size());
        end
    endtask

    task automatic test_ignored_start();
        bit ok;
        clear_logs();
        xfer = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        load_xfer(16'h0300);
        do_start(16'h0300, 12'd8);
        tick();
        do_start(16'h0500, 12'd100);
        wait_done(100, ok);
        repeat (5) tick();
        checks++;
        if (!ok || writes_bad() != 0 || done_cnt != 1) begin
            errors++; $display("FAIL ignored_start: got %0d writes %0d bad %0d dones want 2 writes 0 bad 1 done", wr_addr_q.size(), writes_bad(), done_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignored_start_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_abort_fill();
        bit ok;
        clear_logs();
        xfer = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        foreach (xfer[i]) src_q.push_back(xfer[i]);
        do_start(16'h0600, 12'd16);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = (accepted == 6);
        end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(20, ok);
        checks++;
        if (!ok || done_cnt != 1) begin errors++; $display("FAIL abort_fill_done: got %0d dones want 1", done_cnt); end
        checks++;
        if (wr_addr_q.size() != 1) begin
            errors++; $display("FAIL abort_fill_count: got %0d writes want 1", wr_addr_q.size());
        end else begin
            checks++;
            if (wr_addr_q[0] !== 16'h0600 || wr_dat_q[0] !== 32'h13121110 || wr_be_q[0] !== 4'hF) begin
                errors++; $display("FAIL abort_fill_word: got %h/%h/%h want 0600/13121110/f", wr_addr_q[0], wr_dat_q[0], wr_be_q[0]);
            end
        end
    endtask

    task automatic test_abort_write();
        bit ok;
        clear_logs();
        for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h20 + i));
        stall_mode = 2;
        do_start(16'h0700, 12'd8);
        wait_mwrite(30, ok);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();
        checks++;
        if (!ok || bus.m_write !== 1'b1 || bus.m_address !== 16'h0700) begin
            errors++; $display("FAIL abort_write_held: m_write %b addr %h want 1 0700", bus.m_write, bus.m_address);
        end
        stall_mode = 0;
        wait_done(20, ok);
        repeat (3) tick();
        checks++;
        if (!ok || done_cnt != 1 || wr_addr_q.size() != 1) begin
            errors++; $display("FAIL abort_write_end: got %0d dones %0d writes want 1 1", done_cnt, wr_addr_q.size());
        end else begin
            checks++;
            if (wr_dat_q[0] !== 32'h23222120 || accepted != 4) begin
                errors++; $display("FAIL abort_write_word: got %h after %0d bytes want 23222120 after 4", wr_dat_q[0], accepted);
            end
        end
        src_q.delete();
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        clear_logs();
        for (int i = 0; i < 4; i++) src_q.push_back(8'(8'h40 + i));
        stall_mode = 2;
        do_start(16'h0800, 12'd4);
        wait_mwrite(30, ok);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (!ok || {bus.m_write, bus.m_chipselect, busy, bus.s_ready} !== 4'b0000) begin
            errors++; $display("FAIL reset_mid_ctrl: got %b want 0000", {bus.m_write, bus.m_chipselect, busy, bus.s_ready});
        end
        checks++;
        if ({bus.m_address, bus.m_byteenable, bus.m_writedata} !== 52'h0) begin
            errors++; $display("FAIL reset_mid_bus: got %h/%h/%h want zeros", bus.m_address, bus.m_byteenable, bus.m_writedata);
        end
        stall_mode = 0;
        src_q.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        checks++;
        if ({bus.m_write, busy} !== 2'b00 || wr_addr_q.size() != 0) begin
            errors++; $display("FAIL reset_mid_after: m_write/busy %b writes %0d want 00 0", {bus.m_write, busy}, wr_addr_q.size());
        end
    endtask

    initial begin
        reset_n = 1'b0;
        fork
            drive_loop();
        join_none
        test_reset();
        test_full_sector();
        test_partial_tail();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_ignored_start();
        test_abort_fill();
        test_abort_write();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
